// File: rtl/sprite_fetch_mode3.sv
// Mode-3 object fetcher: on a sprite X match it stalls the pixel pipeline, reads the
// sprite's tile row from VRAM and emits one 8-pixel row. Optional feature: SPRITE_FETCH_OBJ_GATE_EN.
module sprite_fetch_mode3 #(
    parameter int unsigned VRAM_LATENCY = 2,
    parameter int unsigned SPRITE_COUNT = 10,
    parameter logic [15:0] TILE_BASE    = 16'h8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] sprite_queue_in [SPRITE_COUNT-1:0],
    input  logic [7:0]  LCDC,
    input  logic [7:0]  LY,
    input  logic [7:0]  x_pos,
    input  logic [7:0]  vram_dout,
    output logic [15:0] vram_a,
    output logic        vram_rd,
    output logic        stall,
    output logic [15:0] sprite_px,
    output logic [7:0]  sprite_flags,
    output logic        sprite_px_valid,
    output logic        busy
);
    localparam int unsigned IDX_W = (SPRITE_COUNT > 1) ? $clog2(SPRITE_COUNT) : 1;
    localparam int unsigned CNT_W = $clog2(VRAM_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, SCAN, WAIT_LO, WAIT_HI, PUSH} state_t;

    state_t                  state_q, state_d;
    logic [47:0]             queue_q [SPRITE_COUNT-1:0];
    logic [47:0]             queue_d [SPRITE_COUNT-1:0];
    logic [SPRITE_COUNT-1:0] used_q, used_d;
    logic [7:0]              flags_q, flags_d;
    logic [7:0]              lo_q, lo_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [15:0]             vram_a_d, px_d;
    logic [7:0]              sflags_d;
    logic                    vram_rd_d, valid_d, busy_d;

    logic                    hit_c;
    logic [IDX_W-1:0]        hit_idx_c;
    logic [47:0]             sel_c;
    logic [7:0]              row_c, tile_eff_c;
    logic [15:0]             lo_addr_c;
    logic                    unused_bits;

    // Lowest-index valid, unused entry whose X equals the pipeline X
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = 0; i < int'(SPRITE_COUNT); i++) begin
            if (!hit_c && queue_q[i][47:40] == 8'hFE && !used_q[i] && queue_q[i][23:16] == x_pos) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
        end
        if (state_q != SCAN || start) hit_c = 1'b0;
`ifdef SPRITE_FETCH_OBJ_GATE_EN
        if (!LCDC[1]) hit_c = 1'b0;
`endif
    end

    // Tile row address of the hit entry for the current line
    always_comb begin
        sel_c = queue_q[hit_idx_c];
        row_c = LY - (sel_c[31:24] - 8'd16);
        if (sel_c[6]) row_c = (LCDC[2] ? 8'd15 : 8'd7) - row_c;
        tile_eff_c = LCDC[2] ? {sel_c[15:9], row_c[3]} : sel_c[15:8];
        lo_addr_c  = TILE_BASE + {4'b0, tile_eff_c, 4'b0} + {12'b0, row_c[2:0], 1'b0};
    end

    assign unused_bits = ^{sel_c[47:32], row_c[7:4], LCDC[7:3], LCDC[1:0]};

    assign stall = hit_c || state_q == WAIT_LO || state_q == WAIT_HI || state_q == PUSH;

    always_comb begin
        state_d   = state_q;
        queue_d   = queue_q;
        used_d    = used_q;
        flags_d   = flags_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        vram_a_d  = vram_a;
        vram_rd_d = vram_rd;
        px_d      = sprite_px;
        sflags_d  = sprite_flags;
        valid_d   = 1'b0;
        case (state_q)
            SCAN: begin
                if (hit_c) begin
                    used_d[hit_idx_c] = 1'b1;
                    flags_d   = sel_c[7:0];
                    vram_a_d  = lo_addr_c;
                    vram_rd_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (cnt_q == CNT_W'(VRAM_LATENCY)) begin
                    lo_d     = vram_dout;
                    vram_a_d = vram_a + 16'd1;
                    cnt_d    = '0;
                    state_d  = WAIT_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (cnt_q == CNT_W'(VRAM_LATENCY)) begin
                    for (int i = 0; i < 8; i++) begin
                        px_d[15-2*i -: 2] = flags_q[5] ? {vram_dout[i], lo_q[i]}
                                                       : {vram_dout[7-i], lo_q[7-i]};
                    end
                    sflags_d  = flags_q;
                    valid_d   = 1'b1;
                    vram_rd_d = 1'b0;
                    state_d   = PUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PUSH:    state_d = SCAN;
            default: state_d = state_q;
        endcase
        // A new line start overrides everything and abandons any fetch
        if (start) begin
            queue_d   = sprite_queue_in;
            used_d    = '0;
            cnt_d     = '0;
            vram_rd_d = 1'b0;
            valid_d   = 1'b0;
            px_d      = sprite_px;
            sflags_d  = sprite_flags;
            state_d   = SCAN;
        end
        busy_d = state_d == WAIT_LO || state_d == WAIT_HI || state_d == PUSH;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            for (int i = 0; i < int'(SPRITE_COUNT); i++) queue_q[i] <= '0;
            used_q          <= '0;
            flags_q         <= '0;
            lo_q            <= '0;
            cnt_q           <= '0;
            vram_a          <= '0;
            vram_rd         <= 1'b0;
            sprite_px       <= '0;
            sprite_flags    <= '0;
            sprite_px_valid <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_q         <= state_d;
            queue_q         <= queue_d;
            used_q          <= used_d;
            flags_q         <= flags_d;
            lo_q            <= lo_d;
            cnt_q           <= cnt_d;
            vram_a          <= vram_a_d;
            vram_rd         <= vram_rd_d;
            sprite_px       <= px_d;
            sprite_flags    <= sflags_d;
            sprite_px_valid <= valid_d;
            busy            <= busy_d;
        end
    end
endmodule
